// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_pkg
// Purpose  : Opcodes, FSM state type and opcode legality check for alu_pipe.
//            Optional MUL support is controlled by ALU_PIPE_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
        return (op <= OP_MUL);
`else
        return (op < OP_MUL);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Unsigned shift-add multiplier, one partial product per cycle.
//            done is asserted during the last step; product is valid then.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int             c_shw  = $clog2(WIDTH);
    localparam logic [c_shw-1:0] c_last = c_shw'(WIDTH - 1);

    logic                 r_busy;
    logic [c_shw-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Expose the final accumulation combinationally so the caller can
    // capture it on the same edge that retires the last step.
    assign done       = r_busy && (r_cnt == c_last);
    assign product    = w_acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : WIDTH-generic ALU with registered result/flags and valid/ready
//            handshakes. Define ALU_PIPE_MUL_EN to enable the multi-cycle MUL.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    import alu_pipe_pkg::*;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_product;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic                 w_borrow;
    logic                 w_ovf;
    logic                 w_illegal;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    assign w_is_mul = (alu_sel == OP_MUL);

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept && w_is_mul),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_product)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_product  = '0;
`endif

    // Single-cycle datapath; the carry/borrow come from the extra MSB.
    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_borrow  = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = ~is_legal(alu_sel);
        case (alu_sel)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (~a[WIDTH-1] & ~b[WIDTH-1] &  w_res[WIDTH-1]) |
                          ( a[WIDTH-1] &  b[WIDTH-1] & ~w_res[WIDTH-1]);
            end
            OP_SUB: begin
                w_res    = w_diff[WIDTH-1:0];
                w_borrow = w_diff[WIDTH];
                w_ovf    = (~a[WIDTH-1] &  b[WIDTH-1] &  w_res[WIDTH-1]) |
                           ( a[WIDTH-1] & ~b[WIDTH-1] & ~w_res[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_LSL: w_res = a << w_shamt;
            OP_LSR: w_res = a >> w_shamt;
            OP_ASR: w_res = $unsigned($signed(a) >>> w_shamt);
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = w_is_mul ? BUSY : DONE;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            BUSY: begin
                if (w_mul_done) begin
                    w_state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    w_state_next = in_valid ? (w_is_mul ? BUSY : DONE) : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Result/flag register: loaded on a single-cycle accept or MUL retire only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            illegal  <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            result   <= w_res;
            carry    <= w_carry;
            borrow   <= w_borrow;
            overflow <= w_ovf;
            zero     <= (w_res == '0);
            negative <= w_res[WIDTH-1];
            illegal  <= w_illegal;
        end else if (w_mul_done) begin
            result   <= w_product[WIDTH-1:0];
            carry    <= |w_product[2*WIDTH-1:WIDTH];
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= (w_product[WIDTH-1:0] == '0);
            negative <= w_product[WIDTH-1];
            illegal  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe against an arithmetic model.
//            Expectations follow ALU_PIPE_MUL_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 16;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint MAXU = (64'sd1 <<< W) - 1;
    localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
    localparam longint SMIN = -(SMAX + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry, borrow, overflow, zero, negative, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    // flags = {carry, borrow, overflow, zero, negative, illegal}
    typedef struct {
        logic [W-1:0] res;
        logic [5:0]   flags;
        int           lat;
    } exp_t;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] ua, input logic [W-1:0] ub);
        exp_t   e;
        longint ia = longint'(ua);
        longint ib = longint'(ub);
        longint sa = longint'($signed(ua));
        longint sb = longint'($signed(ub));
        int     sh = int'(ub) % W;
        longint r  = 0;
        logic   c = 1'b0, bo = 1'b0, ov = 1'b0, il = 1'b0;
        e.lat = 1;
        case (op)
            4'd0: begin r = ia + ib; c = (r > MAXU); ov = (sa + sb > SMAX) || (sa + sb < SMIN); end
            4'd1: begin r = ia - ib; bo = (ia < ib); ov = (sa - sb > SMAX) || (sa - sb < SMIN); end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            4'd5: r = ia << sh;
            4'd6: r = ia >> sh;
            4'd7: r = sa >>> sh;
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: begin
                if (MUL_EN) begin
                    r = ia * ib; c = (r > MAXU); e.lat = W;
                end else begin
                    il = 1'b1;
                end
            end
            default: il = 1'b1;
        endcase
        e.res   = r[W-1:0];
        e.flags = {c, bo, ov, (e.res == '0), e.res[W-1], il};
        return e;
    endfunction

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain: out_valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb, input string name);
        exp_t       e;
        int         lat;
        logic [5:0] fl;
        e = model(op, va, vb);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: in_ready=%b required 1", name, in_ready);
        end
        alu_sel = op; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble operands after accept; they must have no effect.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); alu_sel = 4'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < W + 4) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_ready: in_ready=%b required 0 at edge %0d", name, in_ready, lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges required %0d", name, lat, e.lat);
        end
        n_tests++;
        if (result !== e.res) begin
            n_fail++;
            $display("FAIL %s result: got %h required %h", name, result, e.res);
        end
        fl = {carry, borrow, overflow, zero, negative, illegal};
        n_tests++;
        if (fl !== e.flags) begin
            n_fail++;
            $display("FAIL %s flags(c,b,v,z,n,i): got %b required %b", name, fl, e.flags);
        end
        drain(name);
    endtask

    task automatic test_reset();
        logic [5:0] fl;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        fl = {carry, borrow, overflow, zero, negative, illegal};
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || fl !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b result=%h flags=%b required 0/1/0000/000000",
                     out_valid, in_ready, result, fl);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_directed();
        run_op(4'd0, 16'h7FFF, 16'h0001, "add_ovf");
        run_op(4'd0, 16'hFFFF, 16'h0001, "add_carry");
        run_op(4'd1, 16'h0000, 16'h0001, "sub_borrow");
        run_op(4'd2, 16'hFFFF, 16'h0000, "and_zero");
        run_op(4'd1, 16'h8000, 16'h0001, "sub_ovf");
        run_op(4'd7, 16'h8000, 16'h0004, "asr");
        run_op(4'd6, 16'h8000, 16'h0004, "lsr");
        run_op(4'd7, 16'h8000, 16'h0014, "asr_lowbits");
        run_op(4'd5, 16'h0001, 16'h000F, "lsl_max");
        run_op(4'd8, 16'hFFFF, 16'h0001, "slt_true");
        run_op(4'd8, 16'h0001, 16'hFFFF, "slt_false");
        run_op(4'd15, 16'h1234, 16'h5678, "illegal_1111");
        run_op(4'd9, 16'h0100, 16'h0100, "mul_wide");
        run_op(4'd9, 16'h0003, 16'h0005, "mul_small");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e1, e2;
        logic [W-1:0] va, vb;
        logic [5:0] fl;
        va = W'($urandom); vb = W'($urandom);
        e1 = model(4'd0, va, vb);
        alu_sel = 4'd0; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fl = {carry, borrow, overflow, zero, negative, illegal};
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e1.res || fl !== e1.flags) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b result=%h flags=%b required 1/0/%h/%b",
                         i, out_valid, in_ready, result, fl, e1.res, e1.flags);
            end
            a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
        end
        va = W'($urandom); vb = W'($urandom);
        e2 = model(4'd1, va, vb);
        alu_sel = 4'd1; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_follows: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        fl = {carry, borrow, overflow, zero, negative, illegal};
        n_tests++;
        if (out_valid !== 1'b1 || result !== e2.res || fl !== e2.flags) begin
            n_fail++;
            $display("FAIL b2b_result: valid=%b result=%h flags=%b required 1/%h/%b",
                     out_valid, result, fl, e2.res, e2.flags);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid_op();
        logic [5:0] fl;
        bit         seen;
        alu_sel = MUL_EN ? 4'd9 : 4'd0; a = 16'h1234; b = 16'h0FF1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        fl = {carry, borrow, overflow, zero, negative, illegal};
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || fl !== 6'b0) begin
            n_fail++;
            $display("FAIL midop_reset: valid=%b ready=%b result=%h flags=%b required 0/1/0000/000000",
                     out_valid, in_ready, result, fl);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midop_no_valid: out_valid seen=1 required 0");
        end
        run_op(4'd4, 16'hA5A5, 16'h5A5A, "post_reset_xor");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
